snake_px_buffer: RTL
====================

# snake_px_buffer

Avalon-MM responder for the snake game's pixel channel: it answers the reads and writes that the snake controller issues on its `vga_px_*` master port and stores one 16-bit RGB565 word per pixel in on-chip RAM. A second, independent read port lets the VGA scan-out logic fetch pixels. A clear engine fills the frame with a constant colour. Sits between the snake controller's pixel master and the display scanner.

## Interface
- `BASE_ADDR`, 32'h08000000: pixel-buffer base; bits [31:18] must match for a hit.
- `H_PIXELS`, 320: visible columns; valid x is 0..H_PIXELS-1.
- `V_PIXELS`, 240: visible rows; valid y is 0..V_PIXELS-1.
- `CLEAR_COLOR`, 16'h0000: colour written by the clear engine.
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `px_address` in 32: byte address, equal to BASE_ADDR | {y[7:0], x[8:0], 1'b0}.
- `px_read` in 1: read request.
- `px_write` in 1: write request.
- `px_writedata` in 16: pixel colour.
- `px_readdata` out 16: read data; valid in the cycle the read completes.
- `px_waitrequest` out 1: stall; a transfer completes in the cycle where a request is high and this signal is low.
- `clear` in 1: one-cycle pulse that starts a frame fill.
- `busy` out 1: high while the clear engine runs.
- `scan_x` in 9: scanner column.
- `scan_y` in 8: scanner row.
- `scan_pixel` out 16: pixel at (scan_x, scan_y) registered on the previous edge; 0 when that position is out of range.
- `oob_count` out 16: number of out-of-range requests completed; saturates at 16'hFFFF.
- `proto_err` out 1: sticky; set when `px_read` and `px_write` are high together.

## Operation
- Decode:
  - Offset = `px_address`[17:0]. x = [9:1], y = [17:10].
  - Hit when [31:18] == BASE_ADDR[31:18], [0] == 0, x < H_PIXELS and y < V_PIXELS.
- RAM: 2^17 words indexed by {y, x}, with two ports (Avalon/clear port and scan port). Contents are not reset.
- FSM states are IDLE, RD_WAIT, ACK and CLEAR.
- IDLE:
  - `clear` high: go to CLEAR. It has priority over a simultaneous request, which stays stalled.
  - `px_write` high without `px_read`: on a hit, write the RAM at this edge; otherwise drop the write and increment `oob_count`. Go to ACK.
  - `px_read` high: issue the RAM read and go to RD_WAIT. If `px_write` is also high, set `proto_err` and ignore the write.
- RD_WAIT: latch RAM output into `px_readdata`, or 16'h0000 on a miss (a miss also increments `oob_count`). Go to ACK.
- ACK: `px_waitrequest` is low and the transfer completes. Go to IDLE.
- CLEAR:
  - Writes CLEAR_COLOR at (cx, cy), starting at (0,0).
  - cx increments each cycle. When cx reaches H_PIXELS-1 it wraps to 0 and cy increments.
  - After (H_PIXELS-1, V_PIXELS-1) is written, go to IDLE.
  - `clear` pulses during CLEAR are ignored.
- `px_waitrequest` = (`px_read` | `px_write`) & (state != ACK). It is combinational, so it is low when there is no request.
- If the master drops its request in RD_WAIT or ACK, return to IDLE. A write already committed stays committed.
- `busy` = (state == CLEAR).

## Timing
- Reset values:
  - State is IDLE.
  - `px_readdata`, `scan_pixel` and `oob_count` are 0.
  - `proto_err` and `busy` are 0.
  - `px_waitrequest` follows the request with state IDLE, so it is high if a request is present.
- Reset asserted mid-clear or mid-transfer aborts immediately; RAM keeps the partial contents.
- Write latency: 2 cycles (request cycle, then ACK cycle). Back-to-back writes complete every 2 cycles.
- Read latency: 3 cycles (IDLE, RD_WAIT, ACK). `px_readdata` holds its value until the next read completes.
- Clear duration: exactly H_PIXELS*V_PIXELS cycles after the `clear` edge (76800 with defaults). `busy` is high for exactly that many cycles.
- Scan port: 1-cycle latency. It is unaffected by Avalon traffic or clearing.
- A same-address scan read and Avalon write in the same cycle return the old data.

## Test plan
- Write then read:
  - Stimulus: write 16'hFF00 at 0x08000000 | {8'd5, 9'd7, 1'b0}, then read the same address.
  - Response: write completes with waitrequest low on cycle 2; read returns 16'hFF00 on cycle 3. `scan_pixel` for (7,5) reads 16'hFF00 one cycle after the scan coordinates are applied.
- Out of range:
  - Stimulus: write to x=320,y=0; then read y=240; then access with base bits 0x09000000.
  - Response: each access is acknowledged; reads return 0; `oob_count` = 3; RAM is unchanged.
- Clear:
  - Stimulus: pulse `clear` with CLEAR_COLOR=16'h001F, and issue a write during the clear.
  - Response: `busy` is high for 76800 cycles; the write stalls until `busy` falls, then completes; pixels (0,0) and (319,239) read 16'h001F.
- Protocol error:
  - Stimulus: assert `px_read` and `px_write` together.
  - Response: `proto_err` = 1 and stays set; the access is serviced as a read; memory is not written.
- Reset mid-clear:
  - Stimulus: assert `reset_n` low at clear cycle 100.
  - Response: `busy` = 0 immediately; pixels 0..99 hold CLEAR_COLOR and pixel 100 holds its old value.

Source files
------------

// File: rtl/snake_px_buffer.sv
// snake_px_buffer
//   Avalon-MM responder for the snake pixel channel. Stores one RGB565 word
//   per pixel in a 2^17-word on-chip RAM indexed by {y, x}. A second read
//   port serves the VGA scanner. A clear engine fills the frame with
//   CLEAR_COLOR, one pixel per cycle in raster order.
//
// Ports
//   clk            single clock, rising edge
//   reset_n        asynchronous active-low reset
//   px_address     byte address, BASE_ADDR | {y[7:0], x[8:0], 1'b0}
//   px_read        read request
//   px_write       write request
//   px_writedata   pixel colour to write
//   px_readdata    read data, valid in the cycle the read completes
//   px_waitrequest stall; transfer completes when request high and this low
//   clear          one-cycle pulse, starts a frame fill
//   busy           high while the clear engine runs
//   scan_x/scan_y  scanner coordinates
//   scan_pixel     pixel at the coordinates sampled on the previous edge
//   oob_count      completed out-of-range requests, saturating
//   proto_err      sticky, set on simultaneous read and write
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request or a clear pulse
// RD_WAIT | RAM read issued, readdata captured at the end of this cycle
// ACK     | waitrequest low, transfer completes
// CLEAR   | writing CLEAR_COLOR at (cx, cy), one pixel per cycle

module snake_px_buffer #(
   parameter logic [31:0] BASE_ADDR   = 32'h08000000,
   parameter int          H_PIXELS    = 320,
   parameter int          V_PIXELS    = 240,
   parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] px_address,
   input  logic        px_read,
   input  logic        px_write,
   input  logic [15:0] px_writedata,
   output logic [15:0] px_readdata,
   output logic        px_waitrequest,
   input  logic        clear,
   output logic        busy,
   input  logic [8:0]  scan_x,
   input  logic [7:0]  scan_y,
   output logic [15:0] scan_pixel,
   output logic [15:0] oob_count,
   output logic        proto_err
);

   localparam logic [8:0]  X_MAX    = 9'(H_PIXELS - 1);
   localparam logic [7:0]  Y_MAX    = 8'(V_PIXELS - 1);
   localparam logic [16:0] CLR_LAST = 17'(H_PIXELS * V_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, ACK, CLEAR} state_t;

   state_t      state;
   logic [15:0] mem [0:131071];

   logic [8:0]  av_x;
   logic [7:0]  av_y;
   logic        av_hit;
   logic        oob_sat;

   logic [8:0]  cx;
   logic [7:0]  cy;
   logic [16:0] clr_left;

   logic        we_a;
   logic        rd_en;
   logic [16:0] addr_a;
   logic [15:0] wdata_a;
   logic [15:0] rd_q;
   logic        rd_hit;

   logic [15:0] scan_raw;
   logic        scan_ok;

   assign av_x   = px_address[9:1];
   assign av_y   = px_address[17:10];
   assign av_hit = (px_address[31:18] == BASE_ADDR[31:18]) && !px_address[0]
                   && (av_x <= X_MAX) && (av_y <= Y_MAX);
   assign oob_sat = &oob_count;

   assign px_waitrequest = (px_read | px_write) && (state != ACK);
   assign busy           = (state == CLEAR);

   // Port A is shared: the clear engine owns it in CLEAR, the Avalon side otherwise.
   always_comb begin
      we_a    = 1'b0;
      rd_en   = 1'b0;
      addr_a  = {av_y, av_x};
      wdata_a = px_writedata;
      if (state == CLEAR) begin
         we_a    = 1'b1;
         addr_a  = {cy, cx};
         wdata_a = CLEAR_COLOR;
      end else if (state == IDLE && !clear) begin
         rd_en = px_read;
         we_a  = px_write && !px_read && av_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[addr_a] <= wdata_a;
      end
      if (rd_en) begin
         rd_q <= mem[addr_a];
      end
   end

   // Scan port: read-before-write, so a same-cycle write to the same pixel
   // shows the old value.
   always_ff @(posedge clk) begin
      scan_raw <= mem[{scan_y, scan_x}];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_ok <= 1'b0;
      end else begin
         scan_ok <= (scan_x <= X_MAX) && (scan_y <= Y_MAX);
      end
   end

   assign scan_pixel = scan_ok ? scan_raw : 16'h0000;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         px_readdata <= 16'h0000;
         oob_count   <= 16'h0000;
         proto_err   <= 1'b0;
         cx          <= 9'd0;
         cy          <= 8'd0;
         clr_left    <= 17'd0;
         rd_hit      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  state    <= CLEAR;
                  cx       <= 9'd0;
                  cy       <= 8'd0;
                  clr_left <= CLR_LAST;
               end else if (px_read) begin
                  state  <= RD_WAIT;
                  rd_hit <= av_hit;
                  if (px_write) begin
                     proto_err <= 1'b1;
                  end
               end else if (px_write) begin
                  state <= ACK;
                  if (!av_hit && !oob_sat) begin
                     oob_count <= oob_count + 16'd1;
                  end
               end
            end
            RD_WAIT: begin
               if (!(px_read | px_write)) begin
                  state <= IDLE;
               end else begin
                  state       <= ACK;
                  px_readdata <= rd_hit ? rd_q : 16'h0000;
                  if (!rd_hit && !oob_sat) begin
                     oob_count <= oob_count + 16'd1;
                  end
               end
            end
            ACK: begin
               state <= IDLE;
            end
            CLEAR: begin
               // clr_left counts pixels still to write after this one.
               if (clr_left == 17'd0) begin
                  state <= IDLE;
               end else begin
                  clr_left <= clr_left - 17'd1;
                  if (cx == X_MAX) begin
                     cx <= 9'd0;
                     cy <= cy + 8'd1;
                  end else begin
                     cx <= cx + 9'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
